// File: rtl/fixed_dot_pkg.sv
// Shared definitions for the fixed-point dot-product MAC: width helpers,
// the stage valid/last flag encoding and the output resize function.
// Build option: FIXED_DOT_MAC_SAT_EN selects saturation of out-of-range
// results; without it the result wraps to the output width.
package fixed_dot_pkg;

  // Working width for resize arithmetic; wide enough that the rounding add
  // on any supported accumulator can never overflow.
  localparam int FX_W = 128;

  // Occupancy of a pipeline stage: empty bubble, mid-packet beat, last beat.
  typedef enum logic [1:0] {
    BEAT_NONE = 2'b00,
    BEAT_MID  = 2'b01,
    BEAT_LAST = 2'b11
  } beat_e;

  function automatic int prod_w(int wi1, int wf1, int wi2, int wf2);
    return wi1 + wf1 + wi2 + wf2;
  endfunction

  function automatic int tree_w(int p, int lanes);
    return p + $clog2(lanes);
  endfunction

  function automatic int acc_w(int t, int guard);
    return t + guard;
  endfunction

  // Re-scale a signed value from in_frac fraction bits to out_frac, rounding
  // to nearest with ties toward +inf, then fit it into out_int+out_frac bits.
  function automatic logic signed [FX_W-1:0] fx_resize(
    logic signed [FX_W-1:0] value,
    int                     in_frac,
    int                     out_int,
    int                     out_frac
  );
    logic signed [FX_W-1:0] res;
    logic signed [FX_W-1:0] half;
    logic signed [FX_W-1:0] lim_hi;
    logic signed [FX_W-1:0] lim_lo;
    int                     out_w;
    out_w  = out_int + out_frac;
    half   = FX_W'(1);
    lim_hi = FX_W'(1);
    if (out_frac < in_frac) begin
      half = half <<< (in_frac - out_frac - 1);
      res  = (value + half) >>> (in_frac - out_frac);
    end else begin
      res = value <<< (out_frac - in_frac);
    end
`ifdef FIXED_DOT_MAC_SAT_EN
    lim_hi = (lim_hi <<< (out_w - 1)) - FX_W'(1);
    lim_lo = ~lim_hi;
    if (res > lim_hi) begin
      res = lim_hi;
    end else if (res < lim_lo) begin
      res = lim_lo;
    end
`else
    lim_lo = '0;
    // Sign-extend from the output width: two's-complement wrap.
    res = (res <<< (FX_W - out_w)) >>> (FX_W - out_w);
`endif
    return res;
  endfunction

endpackage

// File: rtl/fixed_dot_tree.sv
// Combinational balanced adder tree: sums LANES signed P-bit products into a
// signed T-bit total. Its inputs come straight from the product registers.
module fixed_dot_tree #(
  parameter int LANES = 4,
  parameter int P     = 20,
  parameter int T     = 22
) (
  input  logic [LANES*P-1:0] prods,
  output logic [T-1:0]       sum
);

  localparam int LV = $clog2(LANES);
  localparam int N  = 1 << LV;

  logic signed [T-1:0] nodes [N];

  // Pairwise reduction in place: each level halves the live node count.
  // NOTE: every always_comb output is fully assigned before any conditional
  // logic so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      nodes[i] = T'($signed(prods[i*P +: P]));
    end
    for (int i = LANES; i < N; i++) begin
      nodes[i] = '0;
    end
    for (int l = 0; l < LV; l++) begin
      for (int i = 0; i < (N >> (l + 1)); i++) begin
        nodes[i] = nodes[2*i] + nodes[2*i+1];
      end
    end
    sum = nodes[0];
  end

endmodule

// File: rtl/fixed_dot_mac.sv
// Multi-lane fixed-point dot-product MAC. Each accepted beat multiplies LANES
// signed A/B element pairs, the adder tree sums them, and the sum accumulates
// until the packet's last beat; the total is rounded and resized onto a
// valid/ready output. One global enable stalls all three stages together.
// Build option: FIXED_DOT_MAC_SAT_EN clamps out-of-range results instead of
// wrapping them.
module fixed_dot_mac
  import fixed_dot_pkg::*;
#(
  parameter int LANES     = 4,
  parameter int WI1       = 4,
  parameter int WF1       = 8,
  parameter int WI2       = 3,
  parameter int WF2       = 5,
  parameter int WIO       = 12,
  parameter int WFO       = 10,
  parameter int ACC_GUARD = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [LANES*(WI1+WF1)-1:0]   A_data,
  input  logic                         A_valid,
  output logic                         A_ready,
  input  logic                         A_last,
  input  logic [LANES*(WI2+WF2)-1:0]   B_data,
  input  logic                         B_valid,
  output logic                         B_ready,
  input  logic                         B_last,
  output logic [WIO+WFO-1:0]           out_data,
  output logic                         out_valid,
  input  logic                         out_ready
);

  localparam int WA  = WI1 + WF1;
  localparam int WB  = WI2 + WF2;
  localparam int P   = prod_w(WI1, WF1, WI2, WF2);
  localparam int F   = WF1 + WF2;
  localparam int T   = tree_w(P, LANES);
  localparam int ACC = acc_w(T, ACC_GUARD);
  localparam int OW  = WIO + WFO;

  logic                  en;
  logic                  fire;
  logic [LANES*P-1:0]    prod_c;
  logic [LANES*P-1:0]    s1_prod;
  beat_e                 s1_beat;
  logic [T-1:0]          tree_sum;
  beat_e                 s2_beat;
  logic                  s2_fresh;
  logic signed [ACC-1:0] s2_acc;

  // The whole pipeline advances only when the output register can move.
  assign en      = !out_valid || out_ready;
  assign fire    = A_valid && B_valid && en;
  assign A_ready = en;
  assign B_ready = en;

  // Per-lane signed products of the beat currently offered.
  always_comb begin
    prod_c = '0;
    for (int i = 0; i < LANES; i++) begin
      prod_c[i*P +: P] = P'($signed(A_data[i*WA +: WA])) * P'($signed(B_data[i*WB +: WB]));
    end
  end

  // S1: register products and the beat's occupancy; non-fire cycles are bubbles.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others regardless of evaluation order.
  // NOTE: datapath registers are reset as well, so a mid-packet reset leaves
  // no stale partial sums or products to leak into the next packet.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_prod <= '0;
      s1_beat <= BEAT_NONE;
    end else if (en) begin
      s1_prod <= prod_c;
      if (!fire) begin
        s1_beat <= BEAT_NONE;
      end else if (A_last || B_last) begin
        s1_beat <= BEAT_LAST;
      end else begin
        s1_beat <= BEAT_MID;
      end
    end
  end

  fixed_dot_tree #(
    .LANES (LANES),
    .P     (P),
    .T     (T)
  ) u_tree (
    .prods (s1_prod),
    .sum   (tree_sum)
  );

  // S2: accumulate the tree sum; the first beat after a last beat starts fresh.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_acc   <= '0;
      s2_beat  <= BEAT_NONE;
      s2_fresh <= 1'b1;
    end else if (en) begin
      s2_beat <= s1_beat;
      if (s1_beat != BEAT_NONE) begin
        s2_acc   <= (s2_fresh ? '0 : s2_acc) + ACC'($signed(tree_sum));
        s2_fresh <= (s1_beat == BEAT_LAST);
      end
    end
  end

  // S3: resize a completed packet's total into the output register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (en) begin
      if (s2_beat == BEAT_LAST) begin
        out_data  <= OW'(fx_resize(FX_W'(s2_acc), F, WIO, WFO));
        out_valid <= 1'b1;
      end else begin
        out_data  <= '0;
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/fixed_dot_mac.md
Name: fixed_dot_mac

Overview:
- Parametrised successor to the single-lane fixed-point multiply-accumulator: LANES parallel signed fixed-point multiplies per beat, an adder tree, and accumulation across beats until a packet's last beat.
- Emits one resized, rounded and optionally saturated fixed-point result per packet on a valid/ready output channel.
- Sits between the fixed-point vector sources and the downstream result consumers of the datapath; full backpressure, no dropped beats.

Parameters:
- LANES, 4, multiplier lanes per beat (≥1)
- WI1, 4, integer bits of A elements
- WF1, 8, fraction bits of A elements
- WI2, 3, integer bits of B elements
- WF2, 5, fraction bits of B elements
- WIO, 12, integer bits of out_data
- WFO, 10, fraction bits of out_data
- ACC_GUARD, 8, extra integer bits in the accumulator beyond the tree width

Ports:
- clk  in  1  clock, all flops on rising edge
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- A_data  in  LANES*(WI1+WF1)  packed signed A vector; lane i at bits [i*(WI1+WF1) +: WI1+WF1]
- A_valid  in  1  A beat valid
- A_ready  out  1  A beat accepted when A_valid&&B_valid&&A_ready
- A_last  in  1  last beat of packet (A side)
- B_data  in  LANES*(WI2+WF2)  packed signed B vector, same lane layout
- B_valid  in  1  B beat valid
- B_ready  out  1  equals A_ready
- B_last  in  1  last beat of packet (B side)
- out_data  out  WIO+WFO  signed result
- out_valid  out  1  result valid
- out_ready  in  1  consumer ready

Behaviour:
- Reset: all pipeline registers, accumulator, out_data=0, out_valid=0; A_ready=B_ready=1 after reset deasserts. Reset mid-packet discards the partial sum and any in-flight result.
- Widths: P = WI1+WI2+WF1+WF2 (product, frac F=WF1+WF2); tree T = P+$clog2(LANES); accumulator ACC = T+ACC_GUARD, frac F. All arithmetic signed, sign-extended.
- Beat accept: fire = A_valid&&B_valid&&en. last = A_last|B_last, sampled only on fire.
- Global enable: en = !out_valid || out_ready. A_ready = B_ready = en. When en=0, every stage holds.
- Pipeline (advances only when en=1):
  - S1: register LANES products plus valid/last.
  - S2: adder tree sum; acc_next = (first beat of packet ? 0 : acc) + sum; register acc and last flag.
  - S3: resize acc into the output register; set out_valid.
- Latency: a last beat accepted at cycle t gives out_valid=1 at t+3 with no stalls.
- Throughput: one beat per cycle. Back-to-back packets need no bubble: the beat after a last beat starts a fresh sum.
- Non-fire cycles insert bubbles that leave acc unchanged.
- Resize, fraction:
  - WFO<F: round to nearest, ties toward +inf (add 2^(F-WFO-1), arithmetic shift right).
  - WFO≥F: left-shift (zero pad).
- Resize, integer: handled per Optional Feature.
- Output hold: out_data and out_valid stay stable while out_valid&&!out_ready. Output clears when out_ready=1 and no new result arrives.
- Packet of one beat with last=1: result = that beat's dot product.
- A_last≠B_last: OR is used; no error reported.

Optional Feature:
- Macro FIXED_DOT_MAC_SAT_EN.
- Defined: rounded value outside [-2^(WIO+WFO-1), 2^(WIO+WFO-1)-1] clamps to that bound. The rounding add is done at ACC+1 bits so it cannot overflow.
- Undefined: out_data keeps the low WIO+WFO bits (two's-complement wrap).
- Accumulator overflow beyond ACC always wraps in both builds.

Decomposition:
- Package fixed_dot_pkg holds:
  - width functions (P, T, ACC from parameters)
  - rounding/saturation function fx_resize(value, in_frac, out_int, out_frac)
  - state/flag enum for stage valid/last bits
- One sub-module is natural: fixed_dot_tree (registered-input combinational adder tree, LANES inputs of P bits, T-bit output). Everything else stays in fixed_dot_mac.

Test Plan:
- Single-beat packet, all lanes A=256 (1.0), B=32 (1.0), last=1 -> out_valid at t+3, out_data=4096 (4.0).
- Three-beat packet of the same vectors, last on beat 3 -> single result 12288 (12.0); no output after beats 1-2.
- Rounding: lane0 A=4, B=1, other lanes 0, single beat -> product 2^-11 rounds up to out_data=1.
- Saturation: 20 beats of A=-2048 (-8.0), B=-128 (-4.0), all lanes, sum 2560.0 -> SAT_EN build 2097151; non-SAT build -1572864 (-1536.0).
- Backpressure: result pending with out_ready=0 for 5 cycles -> out_data stable, A_ready=B_ready=0, next packet's beats not accepted; release -> results in order, none lost.
- Reset: drop reset to 0 mid-packet after 2 beats -> out_valid=0 immediately; next 1-beat packet gives only its own sum.
